// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: arbitration states and the
// bundled memory request that the top-level mux drives onto data_memory.
package dmem_arb_pkg;

    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        CORE_PRI   = 2'd0,
        EXT_LOCK   = 2'd1,
        CORE_FORCE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [3:0]             mask;
        logic                   rd_en;
        logic                   wr_en;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Arbitration state machine: decides each cycle whether the core or the
// external requester owns the memory port. Grants are combinational from
// the current requests and registered state; counters enforce ext service
// under core load and bound the length of locked ext bursts.
module dmem_arb_fsm
    import dmem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_MAX     = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_core_req,
    input  logic i_ext_req,
    input  logic i_ext_lock,
    output logic o_grant_core,
    output logic o_grant_ext
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LW = $clog2(LOCK_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

    arb_state_t    r_state;
    logic [SW-1:0] r_starve_cnt;
    logic [LW-1:0] r_lock_cnt;
    logic          w_grant_ext;
    logic          w_grant_core;
    logic [LW-1:0] w_lock_next;

    // Grant decision for this cycle; reset masks both grants.
    always_comb begin
        w_grant_ext = 1'b0;
        unique case (r_state)
            CORE_PRI:   w_grant_ext = i_ext_req && (!i_core_req || (r_starve_cnt == STARVE_TOP));
            EXT_LOCK:   w_grant_ext = i_ext_req;
            CORE_FORCE: w_grant_ext = i_ext_req && !i_core_req;
            default:    w_grant_ext = 1'b0;
        endcase
        if (i_rst) begin
            w_grant_ext = 1'b0;
        end
        w_grant_core = i_core_req && !w_grant_ext && !i_rst;
        w_lock_next  = (r_lock_cnt == LOCK_TOP) ? r_lock_cnt : r_lock_cnt + LW'(1);
    end

    assign o_grant_core = w_grant_core;
    assign o_grant_ext  = w_grant_ext;

    // State and counter update based on this cycle's decision.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= CORE_PRI;
            r_starve_cnt <= '0;
            r_lock_cnt   <= '0;
        end else begin
            unique case (r_state)
                CORE_PRI: begin
                    if (w_grant_ext) begin
                        r_starve_cnt <= '0;
                        if (i_ext_lock) begin
                            r_lock_cnt <= LW'(1);
                            // A one-grant lock limit is already exhausted by the entry grant.
                            r_state    <= (LOCK_TOP == LW'(1)) ? CORE_FORCE : EXT_LOCK;
                        end
                    end else if (w_grant_core && i_ext_req && (r_starve_cnt != STARVE_TOP)) begin
                        r_starve_cnt <= r_starve_cnt + SW'(1);
                    end
                end
                EXT_LOCK: begin
                    if (!i_ext_req) begin
                        r_state    <= CORE_PRI;
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= w_lock_next;
                        // Hitting the limit takes precedence over a voluntary release.
                        if (w_lock_next == LOCK_TOP) begin
                            r_state <= CORE_FORCE;
                        end else if (!i_ext_lock) begin
                            r_state    <= CORE_PRI;
                            r_lock_cnt <= '0;
                        end
                    end
                end
                CORE_FORCE: begin
                    r_state      <= CORE_PRI;
                    r_starve_cnt <= '0;
                    r_lock_cnt   <= '0;
                end
                default: begin
                    r_state      <= CORE_PRI;
                    r_starve_cnt <= '0;
                    r_lock_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core load/store path and an
// external requester. The FSM picks the owner; this level only muxes the
// winner's request onto data_memory and fans read data back out.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_MAX     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_rd_en,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [3:0]        core_mask,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [3:0]        ext_mask,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_mask,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic              mem_cs,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic     w_core_req;
    logic     w_grant_core;
    logic     w_grant_ext;
    mem_req_t w_mem;

    assign w_core_req = core_rd_en | core_wr_en;

    dmem_arb_fsm #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .LOCK_MAX     (LOCK_MAX)
    ) u_fsm (
        .i_clk        (clk),
        .i_rst        (reset),
        .i_core_req   (w_core_req),
        .i_ext_req    (ext_req),
        .i_ext_lock   (ext_lock),
        .o_grant_core (w_grant_core),
        .o_grant_ext  (w_grant_ext)
    );

    // Route the winning requester to memory; no winner leaves the port all-zero.
    always_comb begin
        w_mem = '0;
        if (w_grant_ext) begin
            w_mem.addr  = DMEM_ADDR_W'(ext_addr);
            w_mem.wdata = DMEM_DATA_W'(ext_wdata);
            w_mem.mask  = ext_mask;
            w_mem.rd_en = ~ext_we;
            w_mem.wr_en = ext_we;
        end else if (w_grant_core) begin
            w_mem.addr  = DMEM_ADDR_W'(core_addr);
            w_mem.wdata = DMEM_DATA_W'(core_wdata);
            w_mem.mask  = core_mask;
            w_mem.rd_en = core_rd_en;
            w_mem.wr_en = core_wr_en;
        end
    end

    assign mem_addr   = w_mem.addr[ADDR_W-1:0];
    assign mem_wdata  = w_mem.wdata[DATA_W-1:0];
    assign mem_mask   = w_mem.mask;
    assign mem_rd_en  = w_mem.rd_en;
    assign mem_wr_en  = w_mem.wr_en;
    assign mem_cs     = w_mem.rd_en | w_mem.wr_en;

    assign core_stall = w_core_req & ~w_grant_core & ~reset;
    assign ext_gnt    = w_grant_ext;
    assign core_rdata = mem_rdata;
    assign ext_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a driver issues one request set per
// cycle and queues the reference model's expected response; a monitor on
// the falling edge pops and compares against what the DUT presents.
module tb_dmem_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned LOCK_MAX     = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_rd_en = 1'b0, core_wr_en = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic [3:0]  core_mask = '0;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
    logic [31:0] ext_addr = '0, ext_wdata = '0;
    logic [3:0]  ext_mask = '0;
    logic        ext_gnt;
    logic [31:0] ext_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;
    logic        mem_rd_en, mem_wr_en, mem_cs;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (STARVE_LIMIT),
        .LOCK_MAX     (LOCK_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_rd_en (core_rd_en),
        .core_wr_en (core_wr_en),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_mask  (core_mask),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_lock   (ext_lock),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_mask   (ext_mask),
        .ext_gnt    (ext_gnt),
        .ext_rdata  (ext_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_cs     (mem_cs),
        .mem_rdata  (mem_rdata)
    );

    // Environment data memory: combinational read, byte-masked write at the edge.
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_cs && mem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    typedef struct packed {
        bit          stall;
        bit          gnt;
        bit          cs;
        bit          rd;
        bit          wr;
        bit          chk_crd;
        bit          chk_erd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  mask;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: ownership described as "a burst of N grants so far",
    // "a forced core turn is owed", and "core wins with ext waiting N times".
    int          m_starve = 0;
    int          m_burst = 0;
    bit          m_force = 0;
    logic [31:0] shadow [0:255];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("core_stall", 32'(core_stall), 32'(e.stall));
            chk("ext_gnt",    32'(ext_gnt),    32'(e.gnt));
            chk("mem_cs",     32'(mem_cs),     32'(e.cs));
            chk("mem_rd_en",  32'(mem_rd_en),  32'(e.rd));
            chk("mem_wr_en",  32'(mem_wr_en),  32'(e.wr));
            chk("mem_addr",   mem_addr,        e.addr);
            chk("mem_wdata",  mem_wdata,       e.wdata);
            chk("mem_mask",   32'(mem_mask),   32'(e.mask));
            if (e.chk_crd) chk("core_rdata", core_rdata, e.rdata);
            if (e.chk_erd) chk("ext_rdata",  ext_rdata,  e.rdata);
        end
    end

    function automatic void mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) shadow[a[9:2]][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic step(input bit rst, input bit crd, input bit cwr,
                        input logic [31:0] caddr, input logic [31:0] cwd, input logic [3:0] cm,
                        input bit ereq, input bit ewe, input bit elock,
                        input logic [31:0] eaddr, input logic [31:0] ewd, input logic [3:0] em,
                        output bit gnt);
        exp_t e;
        bit   creq, ext_win, core_win;
        @(posedge clk);
        #1;
        reset = rst;
        core_rd_en = crd; core_wr_en = cwr; core_addr = caddr; core_wdata = cwd; core_mask = cm;
        ext_req = ereq; ext_we = ewe; ext_lock = elock; ext_addr = eaddr; ext_wdata = ewd; ext_mask = em;
        e = '0;
        creq = crd | cwr;
        ext_win = 1'b0;
        core_win = 1'b0;
        if (rst) begin
            m_starve = 0; m_burst = 0; m_force = 0;
        end else begin
            if (m_force)          ext_win = ereq && !creq;
            else if (m_burst > 0) ext_win = ereq;
            else                  ext_win = ereq && (!creq || m_starve == int'(STARVE_LIMIT));
            core_win = creq && !ext_win;
            if (ext_win) begin
                e.addr = eaddr; e.wdata = ewd; e.mask = em; e.rd = !ewe; e.wr = ewe;
                if (!ewe) begin e.chk_erd = 1; e.rdata = shadow[eaddr[9:2]]; end
                else mwrite(eaddr, ewd, em);
            end else if (core_win) begin
                e.addr = caddr; e.wdata = cwd; e.mask = cm; e.rd = crd; e.wr = cwr;
                if (crd) begin e.chk_crd = 1; e.rdata = shadow[caddr[9:2]]; end
                if (cwr) mwrite(caddr, cwd, cm);
            end
            e.cs = e.rd | e.wr;
            if (m_force) begin
                m_force = 0; m_starve = 0; m_burst = 0;
            end else if (m_burst > 0) begin
                if (!ereq) m_burst = 0;
                else begin
                    m_burst++;
                    if (m_burst == int'(LOCK_MAX)) begin m_burst = 0; m_force = 1; end
                    else if (!elock) m_burst = 0;
                end
            end else if (ext_win) begin
                m_starve = 0;
                if (elock) begin
                    m_burst = 1;
                    if (m_burst == int'(LOCK_MAX)) begin m_burst = 0; m_force = 1; end
                end
            end else if (core_win && ereq && m_starve < int'(STARVE_LIMIT)) begin
                m_starve++;
            end
        end
        e.stall = creq && !core_win && !rst;
        e.gnt = ext_win;
        q.push_back(e);
        gnt = ext_win;
    endtask

    initial begin
        bit          g;
        int unsigned n;
        bit          pend, p_we, p_lock;
        logic [31:0] p_addr, p_wd, a, d;
        logic [3:0]  p_m;
        int unsigned op;

        for (int i = 0; i < 256; i++) begin mem[i] = '0; shadow[i] = '0; end

        // Reset held: everything quiet even with both sides requesting.
        step(1, 1, 0, 32'h10, 0, 4'hF, 1, 1, 1, 32'h20, 32'h1, 4'hF, g);
        step(1, 0, 1, 32'h10, 32'h5, 4'hF, 1, 0, 0, 32'h20, 0, 4'hF, g);

        // Idle, core-only write/read, then ext read alone.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        step(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, g);
        step(0, 1, 0, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 0, g);
        step(0, 0, 1, 32'h40, 32'h12345678, 4'b0101, 0, 0, 0, 0, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h40, 0, 4'hF, g);

        // Starvation: ext read held while core loads every cycle.
        n = 0;
        for (int unsigned i = 0; i < 7; i++) begin
            step(0, 1, 0, 32'h10, 0, 4'hF, (n == 0), 0, 0, 32'h40, 0, 4'hF, g);
            if (g) n++;
        end

        // Locked burst of 10 writes against constant core loads.
        n = 0;
        for (int unsigned i = 0; i < 40 && n < 10; i++) begin
            step(0, 1, 0, 32'h40, 0, 4'hF, 1, 1, 1, 32'h80 + 32'(n * 4), 32'hA000 + 32'(n), 4'hF, g);
            if (g) n++;
        end
        step(0, 1, 0, 32'h84, 0, 4'hF, 0, 0, 0, 0, 0, 0, g);

        // Lock release on the 4th grant, then core regains the port.
        n = 0;
        for (int unsigned i = 0; i < 40 && n < 4; i++) begin
            step(0, 1, 0, 32'h88, 0, 4'hF, 1, 1, (n < 3), 32'hC0, 32'hB0 + 32'(n), 4'hF, g);
            if (g) n++;
        end
        for (int unsigned i = 0; i < 3; i++) step(0, 1, 0, 32'hC0, 0, 4'hF, 1, 0, 0, 32'h80, 0, 4'hF, g);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h80, 0, 4'hF, g);

        // Reset mid-burst, then first conflict after release goes to core.
        step(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h90, 32'h1, 4'hF, g);
        step(0, 1, 0, 32'h90, 0, 4'hF, 1, 1, 1, 32'h94, 32'h2, 4'hF, g);
        step(1, 1, 0, 32'h90, 0, 4'hF, 1, 1, 1, 32'h98, 32'h3, 4'hF, g);
        step(0, 1, 0, 32'h90, 0, 4'hF, 1, 1, 1, 32'h98, 32'h3, 4'hF, g);

        // Randomized traffic with ext holding its request until granted.
        pend = 0; p_we = 0; p_lock = 0; p_addr = '0; p_wd = '0; p_m = '0;
        for (int unsigned i = 0; i < 600; i++) begin
            if (!pend && ($urandom_range(0, 9) < 5)) begin
                pend   = 1;
                p_we   = 1'($urandom_range(0, 1));
                p_lock = ($urandom_range(0, 3) != 0);
                p_addr = 32'($urandom_range(0, 31)) << 2;
                p_wd   = $urandom;
                p_m    = 4'($urandom_range(1, 15));
            end
            op = $urandom_range(0, 2);
            a  = 32'($urandom_range(0, 31)) << 2;
            d  = $urandom;
            step(($urandom_range(0, 99) == 0), (op == 1), (op == 2), a, d, 4'($urandom_range(0, 15)),
                 pend, p_we, p_lock, p_addr, p_wd, p_m, g);
            if (g) pend = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);

        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
